hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Parametrised pipeline hazard controller for the RV32 core; generalises the existing load-use/jump stall handler.
- Accepts load-use, control-transfer and memory-busy requests and produces PC hold, per-pipeline-register hold and per-register flush (bubble) controls.
- Supports multi-cycle load-use stalls, configurable flush depth, and a memory-wait freeze.
- Sits beside the decode/hazard-detect logic and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- N_REGS, 4, number of pipeline registers controlled; index 0 = IF/ID.
- LW_STALL_CYC, 1, hold cycles per load-use hazard; must be >=1, 0 is an elaboration error.
- J_FLUSH_DEPTH, 2, number of front registers (index 0..J_FLUSH_DEPTH-1) flushed on a jump/taken branch; must be 1..N_REGS.
- CNT_W, $clog2(LW_STALL_CYC+1), width of the internal stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_lw  in  1  load-use hazard detected in ID.
- stall_j  in  1  jump/taken branch resolved; front of pipe is wrong-path.
- mem_busy  in  1  data/instruction memory not ready; freeze whole pipe.
- pc_stop_update  out  1  1 = PC holds.
- ff_stop_update  out  N_REGS  bit i = 1 holds pipeline register i.
- ff_flush  out  N_REGS  bit i = 1 loads a bubble (NOP) into register i.
- stall_active  out  1  1 while state != IDLE, or while a request is being serviced this cycle.
- perf_lw_cyc, perf_flush, perf_mem_cyc  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Control outputs are combinational from the registered state/counter and the current inputs, giving same-cycle response. State and counter update on the rising edge.
- Reset: state=IDLE, cnt=0. While reset is high and in the first cycle after it, all outputs are 0 unless an input request is present after reset deasserts.
- States: IDLE, LW_STALL, RELEASE.
- Priority every cycle: mem_busy > stall_j > stall_lw.
- mem_busy=1 (any state):
  - pc_stop_update=1, ff_stop_update=all 1, ff_flush=0.
  - State and cnt frozen; no transition.
- stall_j=1 (mem_busy=0, any state):
  - pc_stop_update=0, ff_stop_update=0.
  - ff_flush[J_FLUSH_DEPTH-1:0]=1.
  - Next state IDLE, cnt=0. This aborts any load-use stall, because the jump is older.
- IDLE, stall_lw=1:
  - pc_stop_update=1, ff_stop_update[0]=1, ff_flush[1]=1 (bubble into ID/EX).
  - If LW_STALL_CYC==1, go to RELEASE; else go to LW_STALL with cnt=LW_STALL_CYC-1.
- LW_STALL: same outputs as above regardless of stall_lw. Decrement cnt; when cnt==1, go to RELEASE.
- RELEASE:
  - All control outputs 0.
  - stall_lw is ignored for this one cycle, so the still-present request of the same instruction does not re-stall.
  - Next state IDLE.
- Total load-use hold is exactly LW_STALL_CYC cycles; back-to-back distinct load-use hazards are separated by at least one RELEASE cycle.
- N_REGS==1: ff_flush[1] does not exist, so load-use asserts holds only.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - perf_lw_cyc counts cycles with load-use hold asserted.
  - perf_flush counts stall_j service events.
  - perf_mem_cyc counts mem_busy cycles.
  - All counters are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Not defined: perf_* ports tied to 0 and no counter flops are inferred.

Decomposition:
- Package hazard_pkg:
  - state enum (IDLE, LW_STALL, RELEASE).
  - Register index constants IDX_IF_ID=0, IDX_ID_EX=1, IDX_EX_MEM=2, IDX_MEM_WB=3.
  - Perf counter width constant PERF_W=32.
- Sub-module hazard_sat_cnt: generic saturating increment counter with clock, reset and inc. Instantiated three times under HAZ_PERF_CNT_EN.

Test Plan:
- Load-use, defaults: stall_lw high 2 cycles from IDLE -> cycle0 pc_stop=1, ff_stop=4'b0001, ff_flush=4'b0010; cycle1 all 0 (RELEASE); cycle2 IDLE.
- LW_STALL_CYC=3: stall_lw pulse held -> holds asserted exactly 3 cycles, then 1 RELEASE cycle, then re-stall only on a new request.
- Jump during stall, LW_STALL_CYC=3: stall_j in 2nd stall cycle -> ff_flush=4'b0011, pc_stop=0, ff_stop=0 that cycle; next cycle IDLE with outputs 0.
- mem_busy for 4 cycles mid-LW_STALL (cnt=2) -> ff_stop=4'b1111, pc_stop=1, flush=0 for all 4 cycles; stall resumes with the remaining 2 cycles afterwards.
- Reset asserted mid-LW_STALL -> next cycle state IDLE and outputs 0; with HAZ_PERF_CNT_EN defined, perf counters read 0.
- HAZ_PERF_CNT_EN, counter preloaded to 0xFFFFFFFE by force, 3 mem_busy cycles -> perf_mem_cyc=0xFFFFFFFF and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LW_STALL = 2'd1,
        RELEASE  = 2'd2
    } hz_state_e;

    localparam int IDX_IF_ID  = 0;
    localparam int IDX_ID_EX  = 1;
    localparam int IDX_EX_MEM = 2;
    localparam int IDX_MEM_WB = 3;

    localparam int PERF_W = 32;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter; clears on synchronous reset, sticks at all-ones.
module hazard_sat_cnt
    import hazard_pkg::*;
#(
    parameter int W = PERF_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use hold, jump flush, memory-wait freeze.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int N_REGS        = 4,
    parameter int LW_STALL_CYC  = 1,
    parameter int J_FLUSH_DEPTH = 2,
    parameter int CNT_W         = $clog2(LW_STALL_CYC + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_lw,
    input  logic              stall_j,
    input  logic              mem_busy,
    output logic              pc_stop_update,
    output logic [N_REGS-1:0] ff_stop_update,
    output logic [N_REGS-1:0] ff_flush,
    output logic              stall_active,
    output logic [31:0]       perf_lw_cyc,
    output logic [31:0]       perf_flush,
    output logic [31:0]       perf_mem_cyc
);

    if (LW_STALL_CYC < 1) begin : g_bad_lw_cyc
        $error("hazard_stall_ctrl: LW_STALL_CYC must be >= 1");
    end
    if ((J_FLUSH_DEPTH < 1) || (J_FLUSH_DEPTH > N_REGS)) begin : g_bad_j_depth
        $error("hazard_stall_ctrl: J_FLUSH_DEPTH must be in 1..N_REGS");
    end

    // With N_REGS==1 the ID/EX bit truncates away, leaving a hold-only load-use stall.
    localparam logic [N_REGS-1:0] LW_HOLD_MASK  = N_REGS'(1 << IDX_IF_ID);
    localparam logic [N_REGS-1:0] LW_FLUSH_MASK = N_REGS'(1 << IDX_ID_EX);
    localparam logic [N_REGS-1:0] J_FLUSH_MASK  = {N_REGS{1'b1}} >> (N_REGS - J_FLUSH_DEPTH);

    hz_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lw_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        lw_hold        = 1'b0;
        pc_stop_update = 1'b0;
        ff_stop_update = '0;
        ff_flush       = '0;
        stall_active   = (state != IDLE);

        if (reset) begin
            stall_active = 1'b0;
        end else if (mem_busy) begin
            pc_stop_update = 1'b1;
            ff_stop_update = '1;
            stall_active   = 1'b1;
        end else if (stall_j) begin
            ff_flush     = J_FLUSH_MASK;
            stall_active = 1'b1;
            state_n      = IDLE;
            cnt_n        = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (stall_lw) begin
                        lw_hold = 1'b1;
                        if (LW_STALL_CYC == 1) begin
                            state_n = RELEASE;
                        end else begin
                            state_n = LW_STALL;
                            cnt_n   = CNT_W'(LW_STALL_CYC - 1);
                        end
                    end
                end
                LW_STALL: begin
                    lw_hold = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                RELEASE: state_n = IDLE;
                default: state_n = IDLE;
            endcase

            if (lw_hold) begin
                pc_stop_update = 1'b1;
                ff_stop_update = LW_HOLD_MASK;
                ff_flush       = LW_FLUSH_MASK;
                stall_active   = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    hazard_sat_cnt #(.W(PERF_W)) u_perf_lw (
        .clock (clock),
        .reset (reset),
        .inc   (lw_hold),
        .count (perf_lw_cyc)
    );

    hazard_sat_cnt #(.W(PERF_W)) u_perf_flush (
        .clock (clock),
        .reset (reset),
        .inc   (stall_j & ~mem_busy),
        .count (perf_flush)
    );

    hazard_sat_cnt #(.W(PERF_W)) u_perf_mem (
        .clock (clock),
        .reset (reset),
        .inc   (mem_busy),
        .count (perf_mem_cyc)
    );
`else
    assign perf_lw_cyc  = '0;
    assign perf_flush   = '0;
    assign perf_mem_cyc = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed vector bench for hazard_stall_ctrl: one default instance and one
// with LW_STALL_CYC=3, both driven by the same input sequence.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset    = 1'b1;
    logic stall_lw = 1'b0;
    logic stall_j  = 1'b0;
    logic mem_busy = 1'b0;

    logic       pc_a, pc_b, act_a, act_b;
    logic [3:0] stop_a, stop_b, flush_a, flush_b;
    logic [31:0] plw_a, pfl_a, pmem_a, plw_b, pfl_b, pmem_b;

    hazard_stall_ctrl #(
        .N_REGS        (4),
        .LW_STALL_CYC  (1),
        .J_FLUSH_DEPTH (2)
    ) dut_a (
        .clock          (clk),
        .reset          (reset),
        .stall_lw       (stall_lw),
        .stall_j        (stall_j),
        .mem_busy       (mem_busy),
        .pc_stop_update (pc_a),
        .ff_stop_update (stop_a),
        .ff_flush       (flush_a),
        .stall_active   (act_a),
        .perf_lw_cyc    (plw_a),
        .perf_flush     (pfl_a),
        .perf_mem_cyc   (pmem_a)
    );

    hazard_stall_ctrl #(
        .N_REGS        (4),
        .LW_STALL_CYC  (3),
        .J_FLUSH_DEPTH (2)
    ) dut_b (
        .clock          (clk),
        .reset          (reset),
        .stall_lw       (stall_lw),
        .stall_j        (stall_j),
        .mem_busy       (mem_busy),
        .pc_stop_update (pc_b),
        .ff_stop_update (stop_b),
        .ff_flush       (flush_b),
        .stall_active   (act_b),
        .perf_lw_cyc    (plw_b),
        .perf_flush     (pfl_b),
        .perf_mem_cyc   (pmem_b)
    );

    // Expected output packing: {pc_stop, ff_stop[3:0], ff_flush[3:0], stall_active}
    localparam logic [9:0] Z = 10'b0_0000_0000_0;  // idle
    localparam logic [9:0] H = 10'b1_0001_0010_1;  // load-use hold
    localparam logic [9:0] R = 10'b0_0000_0000_1;  // release cycle
    localparam logic [9:0] J = 10'b0_0000_0011_1;  // jump flush
    localparam logic [9:0] M = 10'b1_1111_0000_1;  // memory freeze

    typedef struct {
        logic       rst;
        logic       lw;
        logic       j;
        logic       mb;
        logic [9:0] exp_a;
        logic [9:0] exp_b;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic r, l, jj, m, input logic [9:0] a, b);
        vec_t v;
        v.rst = r; v.lw = l; v.j = jj; v.mb = m; v.exp_a = a; v.exp_b = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        //            rst lw  j   mb   A  B
        tbl[0]  = mk(1, 0, 0, 0, Z, Z);   // reset
        tbl[1]  = mk(0, 0, 0, 0, Z, Z);
        tbl[2]  = mk(0, 1, 0, 0, H, H);   // lw held: A stalls 1, B stalls 3
        tbl[3]  = mk(0, 1, 0, 0, R, H);
        tbl[4]  = mk(0, 1, 0, 0, H, H);
        tbl[5]  = mk(0, 1, 0, 0, R, R);
        tbl[6]  = mk(0, 0, 0, 0, Z, Z);
        tbl[7]  = mk(0, 1, 0, 0, H, H);   // jump in second stall cycle
        tbl[8]  = mk(0, 1, 1, 0, J, J);
        tbl[9]  = mk(0, 0, 0, 0, Z, Z);
        tbl[10] = mk(0, 1, 0, 0, H, H);   // mem_busy with B at cnt=2
        tbl[11] = mk(0, 0, 0, 1, M, M);
        tbl[12] = mk(0, 0, 0, 1, M, M);
        tbl[13] = mk(0, 0, 0, 1, M, M);
        tbl[14] = mk(0, 0, 0, 1, M, M);
        tbl[15] = mk(0, 0, 0, 0, R, H);
        tbl[16] = mk(0, 0, 0, 0, Z, H);
        tbl[17] = mk(0, 0, 0, 0, Z, R);
        tbl[18] = mk(0, 0, 0, 0, Z, Z);
        tbl[19] = mk(0, 1, 1, 1, M, M);   // priority: mem_busy over all
        tbl[20] = mk(0, 1, 1, 0, J, J);   // priority: jump over load-use
        tbl[21] = mk(0, 0, 0, 0, Z, Z);
        tbl[22] = mk(0, 1, 0, 0, H, H);   // reset mid-stall
        tbl[23] = mk(1, 0, 0, 0, Z, Z);
        tbl[24] = mk(0, 0, 0, 0, Z, Z);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset    = tbl[i].rst;
            stall_lw = tbl[i].lw;
            stall_j  = tbl[i].j;
            mem_busy = tbl[i].mb;
            #2;
            check($sformatf("vecA%0d", i), {22'b0, pc_a, stop_a, flush_a, act_a}, {22'b0, tbl[i].exp_a});
            check($sformatf("vecB%0d", i), {22'b0, pc_b, stop_b, flush_b, act_b}, {22'b0, tbl[i].exp_b});
        end

        // Reset in vector 23 clears every counter, and nothing counted since.
        check("perf_lw_a_after_reset",  plw_a,  32'd0);
        check("perf_fl_a_after_reset",  pfl_a,  32'd0);
        check("perf_mem_a_after_reset", pmem_a, 32'd0);
        check("perf_lw_b_after_reset",  plw_b,  32'd0);

        // Saturation sequence: three memory-wait cycles, A preloaded near full.
        @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
        force dut_a.u_perf_mem.count = 32'hFFFF_FFFE;
        #1;
        release dut_a.u_perf_mem.count;
`endif
        mem_busy = 1'b1;
        repeat (3) @(negedge clk);
        mem_busy = 1'b0;
        stall_j  = 1'b1;
        @(negedge clk);
        stall_j  = 1'b0;
        @(negedge clk);
        #2;
`ifdef HAZ_PERF_CNT_EN
        check("perf_mem_a_saturated", pmem_a, 32'hFFFF_FFFF);
        check("perf_mem_b_count",     pmem_b, 32'd3);
        check("perf_flush_b_count",   pfl_b,  32'd1);
        check("perf_lw_b_idle",       plw_b,  32'd0);
        mem_busy = 1'b1;
        @(negedge clk);
        mem_busy = 1'b0;
        #2;
        check("perf_mem_a_holds",     pmem_a, 32'hFFFF_FFFF);
        check("perf_mem_b_count4",    pmem_b, 32'd4);
`else
        check("perf_mem_a_tied",      pmem_a, 32'd0);
        check("perf_mem_b_tied",      pmem_b, 32'd0);
        check("perf_flush_b_tied",    pfl_b,  32'd0);
`endif
        check("outA_after_seq", {22'b0, pc_a, stop_a, flush_a, act_a}, {22'b0, Z});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
